nios_fprint_debug_cmd_initiator: RTL and testbench

//  Debug-host initiator driving the sysclk side of a Nios II JTAG debug module. Turns a

---
 rtl/nios_fprint_dbg_pkg.sv | 24 ++
 rtl/nios_fprint_debug_cmd_initiator_if.sv | 36 +++
 rtl/nios_fprint_dbg_shift_reg.sv | 43 ++++
 rtl/nios_fprint_debug_cmd_initiator.sv | 122 ++++++++++++
 tb/tb_nios_fprint_debug_cmd_initiator.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/nios_fprint_dbg_pkg.sv
// rtl/nios_fprint_dbg_pkg.sv - shared state encoding, IR codes and defaults for the debug command initiator
package nios_fprint_dbg_pkg;

  localparam int SR_W_DEF     = 38;
  localparam int IR_W_DEF     = 2;
  localparam int SYNC_GAP_DEF = 4;

  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_UIR_WAIT,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_UDR_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/nios_fprint_debug_cmd_initiator_if.sv
// rtl/nios_fprint_debug_cmd_initiator_if.sv - command/response and virtual-JTAG signal bundle
interface nios_fprint_debug_cmd_initiator_if
  import nios_fprint_dbg_pkg::*;
#(
  parameter int SR_W = SR_W_DEF,
  parameter int IR_W = IR_W_DEF
) ();

  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] cmd_data;
  logic            cmd_skip_ir;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [SR_W-1:0] rsp_data;
  logic [SR_W-1:0] cap_data;
  logic [IR_W-1:0] ir_in;
  logic [SR_W-1:0] sr;
  logic            vs_uir;
  logic            vs_cdr;
  logic            vs_sdr;
  logic            vs_udr;
  logic            busy;

  modport master (
    input  cmd_valid, cmd_ir, cmd_data, cmd_skip_ir, rsp_ready, cap_data,
    output cmd_ready, rsp_valid, rsp_data, ir_in, sr, vs_uir, vs_cdr, vs_sdr, vs_udr, busy
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_data, cmd_skip_ir, rsp_ready, cap_data,
    input  cmd_ready, rsp_valid, rsp_data, ir_in, sr, vs_uir, vs_cdr, vs_sdr, vs_udr, busy
  );

endinterface

// File: rtl/nios_fprint_dbg_shift_reg.sv
// rtl/nios_fprint_dbg_shift_reg.sv - DR shift datapath: command shadow, responder sr and captured response
module nios_fprint_dbg_shift_reg
  import nios_fprint_dbg_pkg::*;
#(
  parameter int SR_W = SR_W_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_en,
  input  logic [SR_W-1:0] load_data,
  input  logic            cap_en,
  input  logic [SR_W-1:0] cap_data,
  input  logic            shift_en,
  output logic [SR_W-1:0] sr,
  output logic [SR_W-1:0] rsp_data
);

  logic [SR_W-1:0] shadow;

  // Command bits enter sr at the MSB while captured bits leave at the LSB into rsp_data,
  // so after SR_W shifts sr holds the command and rsp_data holds the capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow   <= '0;
      sr       <= '0;
      rsp_data <= '0;
    end else begin
      if (load_en)
        shadow <= load_data;
      else if (shift_en)
        shadow <= shadow >> 1;

      if (cap_en)
        sr <= cap_data;
      else if (shift_en)
        sr <= {shadow[0], sr[SR_W-1:1]};

      if (shift_en)
        rsp_data <= {sr[0], rsp_data[SR_W-1:1]};
    end
  end

endmodule

// File: rtl/nios_fprint_debug_cmd_initiator.sv
// rtl/nios_fprint_debug_cmd_initiator.sv - sequences UIR/CDR/SDR/UDR virtual-JTAG phases from a parallel command
module nios_fprint_debug_cmd_initiator
  import nios_fprint_dbg_pkg::*;
#(
  parameter int SR_W     = SR_W_DEF,
  parameter int IR_W     = IR_W_DEF,
  parameter int SYNC_GAP = SYNC_GAP_DEF
) (
  input logic                               clk,
  input logic                               reset_n,
  nios_fprint_debug_cmd_initiator_if.master bus
);

  localparam int SC_W = $clog2(SR_W + 1);
  localparam int GC_W = $clog2(SYNC_GAP + 1);

  state_t          state, state_nxt;
  logic [SC_W-1:0] shift_cnt, shift_cnt_nxt;
  logic [GC_W-1:0] gap_cnt, gap_cnt_nxt;
  logic            ir_valid;
  logic            accept;
  logic            skip_uir;

  assign accept   = (state == ST_IDLE) && bus.cmd_valid;
  assign skip_uir = bus.cmd_skip_ir && ir_valid && (bus.cmd_ir == bus.ir_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    shift_cnt_nxt = shift_cnt;
    gap_cnt_nxt   = gap_cnt;
    case (state)
      ST_IDLE:
        if (accept)
          state_nxt = skip_uir ? ST_CDR : ST_UIR;
      ST_UIR: begin
        state_nxt   = ST_UIR_WAIT;
        gap_cnt_nxt = GC_W'(SYNC_GAP - 1);
      end
      ST_UIR_WAIT:
        if (gap_cnt == '0)
          state_nxt = ST_CDR;
        else
          gap_cnt_nxt = gap_cnt - 1'b1;
      ST_CDR: begin
        state_nxt     = ST_SDR;
        shift_cnt_nxt = SC_W'(SR_W - 1);
      end
      ST_SDR:
        if (shift_cnt == '0)
          state_nxt = ST_UDR;
        else
          shift_cnt_nxt = shift_cnt - 1'b1;
      ST_UDR: begin
        state_nxt   = ST_UDR_WAIT;
        gap_cnt_nxt = GC_W'(SYNC_GAP - 1);
      end
      ST_UDR_WAIT:
        if (gap_cnt == '0)
          state_nxt = ST_RESP;
        else
          gap_cnt_nxt = gap_cnt - 1'b1;
      ST_RESP:
        if (bus.rsp_ready)
          state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop in step with state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_cnt     <= '0;
      gap_cnt       <= '0;
      ir_valid      <= 1'b0;
      bus.ir_in     <= '0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.vs_uir    <= 1'b0;
      bus.vs_cdr    <= 1'b0;
      bus.vs_sdr    <= 1'b0;
      bus.vs_udr    <= 1'b0;
    end else begin
      shift_cnt     <= shift_cnt_nxt;
      gap_cnt       <= gap_cnt_nxt;
      if (accept)
        bus.ir_in <= bus.cmd_ir;
      if (state == ST_UIR)
        ir_valid <= 1'b1;
      bus.cmd_ready <= (state_nxt == ST_IDLE);
      bus.busy      <= (state_nxt != ST_IDLE);
      bus.rsp_valid <= (state_nxt == ST_RESP);
      bus.vs_uir    <= (state_nxt == ST_UIR);
      bus.vs_cdr    <= (state_nxt == ST_CDR);
      bus.vs_sdr    <= (state_nxt == ST_SDR);
      bus.vs_udr    <= (state_nxt == ST_UDR);
    end
  end

  nios_fprint_dbg_shift_reg #(
    .SR_W (SR_W)
  ) u_shift_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_en   (accept),
    .load_data (bus.cmd_data),
    .cap_en    (state == ST_CDR),
    .cap_data  (bus.cap_data),
    .shift_en  (state == ST_SDR),
    .sr        (bus.sr),
    .rsp_data  (bus.rsp_data)
  );

endmodule

// File: tb/tb_nios_fprint_debug_cmd_initiator.sv
// tb/tb_nios_fprint_debug_cmd_initiator.sv - directed scoreboard bench for the debug command initiator
module tb_nios_fprint_debug_cmd_initiator;
  import nios_fprint_dbg_pkg::*;

  localparam int SR_W = 38;
  localparam int IR_W = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [SR_W-1:0] exp_q[$];

  nios_fprint_debug_cmd_initiator_if #(.SR_W(SR_W), .IR_W(IR_W)) bus ();

  nios_fprint_debug_cmd_initiator dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.cmd_ready), 64'd1);
    check({tag, "_busy_rsp"}, 64'({bus.busy, bus.rsp_valid}), 64'd0);
    check({tag, "_strobes"}, 64'({bus.vs_uir, bus.vs_cdr, bus.vs_sdr, bus.vs_udr}), 64'd0);
    check({tag, "_ir_in"}, 64'(bus.ir_in), 64'd0);
    check({tag, "_sr"}, 64'(bus.sr), 64'd0);
    check({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  // Issue one command, trace the phase timing cycle by cycle, then complete the response
  // after holding rsp_ready low for `hold` cycles with a competing cmd_valid asserted.
  task automatic do_cmd(input string tag, input logic [IR_W-1:0] ir, input logic [SR_W-1:0] data,
                        input logic skip, input logic [SR_W-1:0] cap, input int exp_uir,
                        input int exp_cdr, input int exp_rsp, input int hold);
    int c, uir_c, cdr_c, udr_c, sdr_n;
    logic [SR_W-1:0] sr_udr;
    bus.cmd_ir = ir; bus.cmd_data = data; bus.cmd_skip_ir = skip; bus.cap_data = cap;
    bus.cmd_valid = 1'b1;
    wait_ready(tag);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    exp_q.push_back(cap);
    c = 1; uir_c = 0; cdr_c = 0; udr_c = 0; sdr_n = 0; sr_udr = '0;
    while (!bus.rsp_valid && c < 100) begin
      if (bus.vs_uir && uir_c == 0) uir_c = c;
      if (bus.vs_cdr && cdr_c == 0) cdr_c = c;
      if (bus.vs_sdr) sdr_n++;
      if (bus.vs_udr) begin udr_c = c; sr_udr = bus.sr; end
      @(negedge clk);
      c++;
    end
    check({tag, "_uir_cycle"}, 64'(uir_c), 64'(exp_uir));
    check({tag, "_cdr_cycle"}, 64'(cdr_c), 64'(exp_cdr));
    check({tag, "_sdr_count"}, 64'(sdr_n), 64'(SR_W));
    check({tag, "_udr_cycle"}, 64'(udr_c), 64'(exp_rsp - 5));
    check({tag, "_sr_at_udr"}, 64'(sr_udr), 64'(data));
    check({tag, "_rsp_cycle"}, 64'(c), 64'(exp_rsp));
    for (int h = 0; h < hold; h++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = ~data;
      check({tag, "_hold_valid_ready"}, 64'({bus.rsp_valid, bus.cmd_ready}), 64'b10);
      check({tag, "_hold_data"}, 64'(bus.rsp_data), 64'(cap));
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    check({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(exp_q.pop_front()));
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "_post_idle"}, 64'({bus.cmd_ready, bus.busy, bus.rsp_valid}), 64'b100);
  endtask

  initial begin
    int c;
    bus.cmd_valid = 1'b0; bus.cmd_ir = '0; bus.cmd_data = '0; bus.cmd_skip_ir = 1'b0;
    bus.rsp_ready = 1'b0; bus.cap_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // First command after reset: skip_ir is requested but ir_valid is clear, so UIR is issued.
    do_cmd("t1", IR_OCIMEM, 38'h2A_5555_5555, 1'b1, 38'h3F_0000_0001, 1, 6, 50, 0);
    do_cmd("t2", IR_TRACEMEM, 38'h3F_FFFF_FFFF, 1'b0, 38'h15_A5A5_3C3C, 1, 6, 50, 0);
    do_cmd("t3_skip", IR_TRACEMEM, 38'h00_1234_5678, 1'b1, 38'h2B_DEAD_BEEF, 0, 1, 45, 0);
    do_cmd("t3_newir", IR_BREAK, 38'h01_0000_0000, 1'b1, 38'h00_0000_0000, 1, 6, 50, 0);
    do_cmd("t4_bp", IR_BREAK, 38'h20_0F0F_F0F0, 1'b1, 38'h1C_3333_CCCC, 0, 1, 45, 10);

    // Reset during the 20th SDR cycle (IR skipped, so SDR starts at cycle 2).
    bus.cmd_ir = IR_BREAK; bus.cmd_data = 38'h3A_AAAA_5555; bus.cmd_skip_ir = 1'b1;
    bus.cap_data = 38'h11_1111_1111; bus.cmd_valid = 1'b1;
    wait_ready("t5");
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_in_sdr", 64'(bus.vs_sdr), 64'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t5_ready_after", 64'(bus.cmd_ready), 64'd1);
    // ir_in is back to 0, so only the cleared ir_valid can force this UIR.
    do_cmd("t5_uir", IR_OCIMEM, 38'h05_5AA5_0FF0, 1'b1, 38'h22_8844_2211, 1, 6, 50, 0);

    // Two back-to-back commands with rsp_ready held high.
    bus.rsp_ready = 1'b1;
    bus.cap_data = 38'h0F_CAFE_F00D;
    bus.cmd_ir = IR_TRACECTRL; bus.cmd_data = 38'h12_3456_789A; bus.cmd_skip_ir = 1'b0;
    bus.cmd_valid = 1'b1;
    wait_ready("t6_a");
    @(negedge clk);
    exp_q.push_back(38'h0F_CAFE_F00D);
    bus.cmd_data = 38'h2E_DCBA_9876; bus.cmd_skip_ir = 1'b1;
    c = 1;
    while (!bus.rsp_valid && c < 100) begin
      if (c == 7) bus.cap_data = 38'h30_0BAD_C0DE;
      @(negedge clk);
      c++;
    end
    check("t6_a_rsp_cycle", 64'(c), 64'd50);
    check("t6_a_rsp_data", 64'(bus.rsp_data), 64'(exp_q.pop_front()));
    @(negedge clk);
    check("t6_idle_gap", 64'({bus.cmd_ready, bus.busy}), 64'b10);
    exp_q.push_back(38'h30_0BAD_C0DE);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("t6_b_accepted", 64'({bus.busy, bus.vs_cdr, bus.vs_uir}), 64'b110);
    c = 1;
    while (!bus.rsp_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("t6_b_rsp_cycle", 64'(c), 64'd45);
    check("t6_b_rsp_data", 64'(bus.rsp_data), 64'(exp_q.pop_front()));
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("t6_b_done", 64'({bus.cmd_ready, bus.rsp_valid}), 64'b10);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
